mem_wb_writeback: RTL
=====================

# mem_wb_writeback

Writeback stage and architectural register file of the five-stage MIPS pipeline; the consumer of the 71-bit MEM/WB pipeline bundle. Each cycle it decodes the bundle, selects the load data or the ALU result, and commits it to one of 32 general registers on the next rising clock. It serves the decode stage with two combinational read ports that see the in-flight write (write-through bypass). It exports the writeback value and match flags for EX-stage forwarding, plus a retired-write counter.

## Interface
- COUNT_W, 32, width of the retired-write counter (wraps modulo 2^COUNT_W)
- clock  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- memwb  in  71  MEM/WB bundle: [31:0] load data, [36:32] dest reg, [37] RegWrite, [69:38] ALU result/address, [70] MemtoReg
- rs_addr  in  5  read port A register index (decode stage)
- rt_addr  in  5  read port B register index (decode stage)
- rs_data  out  32  read port A data, bypassed
- rt_data  out  32  read port B data, bypassed
- wb_data  out  32  value being written back this cycle
- wb_reg  out  5  destination register this cycle (memwb[36:32])
- wb_en  out  1  effective write enable: memwb[37] & (memwb[36:32] != 0)
- fwd_rs  out  1  wb_en & (wb_reg == rs_addr)
- fwd_rt  out  1  wb_en & (wb_reg == rt_addr)
- retire_cnt  out  COUNT_W  number of committed register writes since reset

## Operation
- Data select: wb_data = memwb[70] ? memwb[31:0] : memwb[69:38]. Pure combinational, no width extension.
- Commit: on a rising clock with wb_en=1, regs[wb_reg] <= wb_data and retire_cnt <= retire_cnt + 1. When wb_en=0, no register changes and the counter holds.
- Register 0: reads always return 0. Writes to index 0 are discarded and not counted, even with RegWrite=1.
- Read ports: rs_data = (rs_addr==0) ? 0 : (wb_en & wb_reg==rs_addr) ? wb_data : regs[rs_addr]. rt_data follows the same rule. The bypass gives a decode-stage read in the same cycle as a write the new value, so no separate half-cycle register-file write is needed.
- Bubble: an all-zero bundle, which is the MEM/WB reset value, has RegWrite=0 and is a no-op.
- The block has no stall input. The bundle is consumed every cycle, and upstream holds it constant when it must not commit twice. A held bundle with wb_en=1 rewrites the same value and increments retire_cnt each cycle. This is accepted behaviour.
- Unknown/X on memwb[37] must not corrupt registers in simulation. Treat it as a write only when it is exactly 1.

## Timing
- Reset: asserting rst clears all 31 writable registers to 0 and retire_cnt to 0 immediately, with no clock needed. rs_data and rt_data read 0 while memwb is 0. wb_data, wb_reg, wb_en, fwd_rs and fwd_rt are combinational from memwb and are not gated by rst.
- Reset has priority over a coincident clock edge. No write commits in any cycle where rst is high.
- Write latency: memwb is valid after edge N, and the register is updated at edge N+1. Read ports reflect the new value combinationally during cycle N through the bypass, and directly from the storage array from N+1 onward.
- Rs and rt read zero-delay paths: rs_addr/rt_addr → rs_data/rt_data, and memwb → rs_data/rt_data.
- Both read ports may address wb_reg at once; both bypass.
- Counter wrap: at all-ones, the next committed write gives 0. No sticky overflow flag.

## Test plan
- Reset: load regs 1..31 with nonzero values, assert rst mid-cycle with no clock edge. Required: rs_data/rt_data read 0 for all indices, retire_cnt=0 immediately.
- ALU vs load select: memwb with dest=5, RegWrite=1, MemtoReg=0, ALU=0x0000_1234, load=0xDEAD_BEEF, then one clock. Required: reg5=0x1234. Repeat with MemtoReg=1 and dest=6. Required: reg6=0xDEADBEEF, retire_cnt=2.
- Bypass/forward: reg7=0x11 committed earlier, then bundle dest=7, RegWrite=1, ALU=0x22 with rs_addr=rt_addr=7. Before the edge: rs_data=rt_data=0x22, fwd_rs=fwd_rt=1. After the edge with a bubble bundle: both read 0x22 and fwd_rs=fwd_rt=0.
- $zero: bundle dest=0, RegWrite=1, ALU=0xFFFF_FFFF, rs_addr=0. Required: rs_data=0, wb_en=0, fwd_rs=0; after the edge reg0 still reads 0 and retire_cnt is unchanged.
- Gated write: bundle dest=9, RegWrite=0, ALU=0xABCD for 3 cycles. Required: reg9 keeps its old value, retire_cnt unchanged.
- Counter wrap with COUNT_W=4: 17 committed writes to reg 3. Required: retire_cnt=1 and reg3 holds the 17th value.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback
// Writeback stage and architectural register file of the five-stage MIPS
// pipeline. Decodes the 71-bit MEM/WB bundle, picks load data or the ALU
// result, and commits it to one of 31 writable registers on the next rising
// clock. Two combinational read ports serve decode and see the in-flight write
// through a bypass, so decode never needs a half-cycle register-file write.
// The writeback value and match flags are exported for EX-stage forwarding,
// together with a counter of committed writes.

module mem_wb_writeback #(
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [70:0]        memwb,
    input  logic [4:0]         rs_addr,
    input  logic [4:0]         rt_addr,
    output logic [31:0]        rs_data,
    output logic [31:0]        rt_data,
    output logic [31:0]        wb_data,
    output logic [4:0]         wb_reg,
    output logic               wb_en,
    output logic               fwd_rs,
    output logic               fwd_rt,
    output logic [COUNT_W-1:0] retire_cnt
);

    // Bundle field positions
    localparam int LD_LSB   = 0;
    localparam int DST_LSB  = 32;
    localparam int RW_BIT   = 37;
    localparam int ALU_LSB  = 38;
    localparam int M2R_BIT  = 70;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Decoded bundle fields
    logic [31:0]        ld_data_s;
    logic [31:0]        alu_data_s;
    logic [4:0]         dst_reg_s;
    logic               reg_write_s;
    logic               mem_to_reg_s;

    // Writeback path
    logic [31:0]        wb_data_s;
    logic               wb_en_s;

    // Storage lookups (before bypass)
    logic [31:0]        rs_store_s;
    logic [31:0]        rt_store_s;

    // Bypassed read data
    logic [31:0]        rs_data_s;
    logic [31:0]        rt_data_s;
    logic               fwd_rs_s;
    logic               fwd_rt_s;

    // Architectural state; register 0 has no storage and always reads 0
    logic [31:0]        regs_q [1:31];
    logic [COUNT_W-1:0] retire_q;
    logic [COUNT_W-1:0] retire_d;

    // Split the MEM/WB bundle into its fields
    always_comb begin
        ld_data_s    = memwb[LD_LSB +: 32];
        dst_reg_s    = memwb[DST_LSB +: 5];
        reg_write_s  = memwb[RW_BIT];
        alu_data_s   = memwb[ALU_LSB +: 32];
        mem_to_reg_s = memwb[M2R_BIT];
    end

    // Select the writeback value and qualify the write enable.
    // An X on RegWrite makes wb_en_s X, and an X condition in the sequential
    // blocks below takes the hold branch, so registers are never corrupted.
    always_comb begin
        if (mem_to_reg_s == 1'b1) begin
            wb_data_s = ld_data_s;
        end else begin
            wb_data_s = alu_data_s;
        end
        wb_en_s = (reg_write_s == 1'b1) && (dst_reg_s != 5'd0);
    end

    // Look up both read indices in the storage array
    always_comb begin
        rs_store_s = 32'h0000_0000;
        rt_store_s = 32'h0000_0000;
        for (int i = 1; i < 32; i++) begin
            rs_store_s = (rs_addr == 5'(i)) ? regs_q[i] : rs_store_s;
            rt_store_s = (rt_addr == 5'(i)) ? regs_q[i] : rt_store_s;
        end
    end

    // Forward-match flags for both ports
    always_comb begin
        fwd_rs_s = wb_en_s && (dst_reg_s == rs_addr);
        fwd_rt_s = wb_en_s && (dst_reg_s == rt_addr);
    end

    // Read port A: $zero first, then the in-flight write, then storage
    always_comb begin
        if (rs_addr == 5'd0) begin
            rs_data_s = 32'h0000_0000;
        end else if (fwd_rs_s) begin
            rs_data_s = wb_data_s;
        end else begin
            rs_data_s = rs_store_s;
        end
    end

    // Read port B: same priority as port A
    always_comb begin
        if (rt_addr == 5'd0) begin
            rt_data_s = 32'h0000_0000;
        end else if (fwd_rt_s) begin
            rt_data_s = wb_data_s;
        end else begin
            rt_data_s = rt_store_s;
        end
    end

    // Next retired-write count; wraps naturally at all-ones
    always_comb begin
        if (wb_en_s) begin
            retire_d = retire_q + CNT_ONE;
        end else begin
            retire_d = retire_q;
        end
    end

    // Register file commit; reset clears every writable register at once
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wb_en_s && (dst_reg_s == 5'(i))) begin
                    regs_q[i] <= wb_data_s;
                end else begin
                    regs_q[i] <= regs_q[i];
                end
            end
        end
    end

    // Retired-write counter
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            retire_q <= {COUNT_W{1'b0}};
        end else begin
            retire_q <= retire_d;
        end
    end

    // Output drive
    assign rs_data    = rs_data_s;
    assign rt_data    = rt_data_s;
    assign wb_data    = wb_data_s;
    assign wb_reg     = dst_reg_s;
    assign wb_en      = wb_en_s;
    assign fwd_rs     = fwd_rs_s;
    assign fwd_rt     = fwd_rt_s;
    assign retire_cnt = retire_q;

endmodule
